// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: FSM-sequenced datapath sharing one ALU over a unified
// memory port with a ready handshake, plus retired-instruction count and illegal-opcode trap.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          EXT_OPS  = 1'b1,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      adr,
  output logic             memread,
  output logic             memwrite,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  input  logic             memready,
  output logic [31:0]      pc,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, BNEEX, ADDIEX, LOGIEX, IMMWB, JEX, TRAP
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101,
                         OP_ADDI  = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI   = 6'b001101, OP_LW   = 6'b100011,
                         OP_SW    = 6'b101011;

  state_t          state, dispatch;
  logic [31:0]     pc_r, ir, a, b, aluout, data;
  logic            trap_r;
  logic [CNT_W-1:0] instret_r;
  logic [31:0]     rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext, zext, rs_val, rt_val;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign sext   = {{16{ir[15]}}, ir[15:0]};
  assign zext   = {16'h0000, ir[15:0]};
  assign rs_val = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf[rt];

  // Shared ALU: operand and operation steering depend only on the current state.
  alu_op_t     alu_op;
  logic [31:0] alu_x, alu_y, alu_r;
  logic        funct_ok, zero;

  always_comb begin
    alu_x    = pc_r;
    alu_y    = 32'd4;
    alu_op   = ALU_ADD;
    funct_ok = 1'b1;
    case (state)
      DECODE:         alu_y = {sext[29:0], 2'b00};
      MEMADR, ADDIEX: begin alu_x = a; alu_y = sext; end
      BEQEX, BNEEX:   begin alu_x = a; alu_y = b; alu_op = ALU_SUB; end
      LOGIEX: begin
        alu_x  = a;
        alu_y  = zext;
        alu_op = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
      end
      RTYPEEX: begin
        alu_x = a;
        alu_y = b;
        case (funct)
          6'b100000: alu_op = ALU_ADD;
          6'b100010: alu_op = ALU_SUB;
          6'b100100: alu_op = ALU_AND;
          6'b100101: alu_op = ALU_OR;
          6'b101010: alu_op = ALU_SLT;
          default:   funct_ok = 1'b0;
        endcase
      end
      default: ;
    endcase
    case (alu_op)
      ALU_SUB: alu_r = alu_x - alu_y;
      ALU_AND: alu_r = alu_x & alu_y;
      ALU_OR:  alu_r = alu_x | alu_y;
      ALU_SLT: alu_r = {31'd0, $signed(alu_x) < $signed(alu_y)};
      default: alu_r = alu_x + alu_y;
    endcase
  end

  assign zero = (alu_r == 32'h0);

  always_comb begin
    case (opcode)
      OP_LW, OP_SW: dispatch = MEMADR;
      OP_RTYPE:     dispatch = RTYPEEX;
      OP_BEQ:       dispatch = BEQEX;
      OP_BNE:       dispatch = EXT_OPS ? BNEEX : TRAP;
      OP_ADDI:      dispatch = ADDIEX;
      OP_ANDI,
      OP_ORI:       dispatch = EXT_OPS ? LOGIEX : TRAP;
      OP_J:         dispatch = JEX;
      default:      dispatch = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc_r      <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      aluout    <= '0;
      data      <= '0;
      trap_r    <= 1'b0;
      instret_r <= '0;
    end else begin
      case (state)
        FETCH: if (memready) begin
          ir    <= readdata;
          pc_r  <= alu_r;
          state <= DECODE;
        end
        DECODE: begin
          a      <= rs_val;
          b      <= rt_val;
          aluout <= alu_r;
          state  <= dispatch;
        end
        MEMADR: begin
          aluout <= alu_r;
          state  <= (opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: if (memready) begin
          data  <= readdata;
          state <= MEMWB;
        end
        MEMWB: begin
          if (rt != 5'd0) rf[rt] <= data;
          instret_r <= instret_r + CNT_W'(1);
          state     <= FETCH;
        end
        MEMWR: if (memready) begin
          instret_r <= instret_r + CNT_W'(1);
          state     <= FETCH;
        end
        RTYPEEX: begin
          aluout <= alu_r;
          state  <= funct_ok ? RTYPEWB : TRAP;
        end
        RTYPEWB: begin
          if (rd != 5'd0) rf[rd] <= aluout;
          instret_r <= instret_r + CNT_W'(1);
          state     <= FETCH;
        end
        BEQEX, BNEEX: begin
          if ((state == BEQEX) == zero) pc_r <= aluout;
          instret_r <= instret_r + CNT_W'(1);
          state     <= FETCH;
        end
        ADDIEX, LOGIEX: begin
          aluout <= alu_r;
          state  <= IMMWB;
        end
        IMMWB: begin
          if (rt != 5'd0) rf[rt] <= aluout;
          instret_r <= instret_r + CNT_W'(1);
          state     <= FETCH;
        end
        JEX: begin
          pc_r      <= {pc_r[31:28], ir[25:0], 2'b00};
          instret_r <= instret_r + CNT_W'(1);
          state     <= FETCH;
        end
        TRAP:    trap_r <= 1'b1;
        default: state  <= TRAP;
      endcase
    end
  end

  assign memread   = !reset && (state == FETCH || state == MEMRD);
  assign memwrite  = !reset && (state == MEMWR);
  assign adr       = (state == FETCH) ? pc_r : aluout;
  assign writedata = b;
  assign pc        = pc_r;
  assign trap      = trap_r;
  assign instret   = instret_r;
endmodule

// File: tb/tb_mips_multicycle.sv
// Directed-program bench: stores are checked by a scoreboard monitor, while
// pc/instret/trap/timing are checked at known retire points.
module tb_mips_multicycle;
  logic        clk, reset, dinit;
  logic [31:0] adr, writedata, readdata, pc;
  logic        memread, memwrite, memready, trap;
  logic [31:0] instret;

  logic [31:0] adr2, writedata2, readdata2, pc2, instret2;
  logic        memread2, memwrite2, trap2;

  mips_multicycle #(.RESET_PC(32'h0), .EXT_OPS(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .adr(adr), .memread(memread), .memwrite(memwrite),
    .writedata(writedata), .readdata(readdata), .memready(memready), .pc(pc),
    .trap(trap), .instret(instret));

  mips_multicycle #(.RESET_PC(32'h0), .EXT_OPS(1'b0), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .adr(adr2), .memread(memread2), .memwrite(memwrite2),
    .writedata(writedata2), .readdata(readdata2), .memready(1'b1), .pc(pc2),
    .trap(trap2), .instret(instret2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rom(input int w);
    case (w)
      0:  rom = 32'h20020005; // addi $2,$0,5
      1:  rom = 32'h2003000C; // addi $3,$0,12
      2:  rom = 32'h00432020; // add  $4,$2,$3
      3:  rom = 32'hAC040054; // sw   $4,84($0)
      4:  rom = 32'h8C050054; // lw   $5,84($0)
      5:  rom = 32'hAC050080; // sw   $5,128($0)
      6:  rom = 32'h08000008; // j    0x20
      8:  rom = 32'h10420002; // beq  $2,$2,+2
      11: rom = 32'h14420002; // bne  $2,$2,+2
      12: rom = 32'h3406FFFF; // ori  $6,$0,0xFFFF
      13: rom = 32'h30C700F0; // andi $7,$6,0x00F0
      14: rom = 32'hAC060084; // sw   $6,132($0)
      15: rom = 32'hAC070088; // sw   $7,136($0)
      16: rom = 32'h2009FFFF; // addi $9,$0,-1
      17: rom = 32'h200A0001; // addi $10,$0,1
      18: rom = 32'h012A402A; // slt  $8,$9,$10
      19: rom = 32'h08000016; // j    0x58
      22: rom = 32'hAC08008C; // sw   $8,140($0)
      23: rom = 32'h00430020; // add  $0,$2,$3
      24: rom = 32'hAC000090; // sw   $0,144($0)
      25: rom = 32'h00435822; // sub  $11,$2,$3
      26: rom = 32'hAC0B0094; // sw   $11,148($0)
      27: rom = 32'h00436025; // or   $12,$2,$3
      28: rom = 32'hAC0C0098; // sw   $12,152($0)
      default: rom = 32'hFC000000; // illegal opcode, also the untouched-data pattern
    endcase
  endfunction

  // Unified memory; only data accesses (adr != pc) see the configurable wait states.
  logic [31:0] mem [64];
  int          dstall = 0, wcnt = 0;
  logic        dreq;

  assign readdata  = mem[adr[7:2]];
  assign readdata2 = (adr2 == 32'h0) ? 32'h3406FFFF : 32'hFC000000;
  assign dreq      = memwrite || (memread && adr != pc);

  always_comb begin
    memready = 1'b1;
    if (dreq) memready = (wcnt >= dstall);
  end

  always @(posedge clk) begin
    if (dreq && !memready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (dinit) for (int i = 0; i < 64; i++) mem[i] <= rom(i);
    else if (memwrite && memready) mem[adr[7:2]] <= writedata;
  end

  typedef struct { logic [31:0] adr; logic [31:0] data; } store_t;
  store_t exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (memread && memwrite) begin
        nerr++;
        $display("FAIL rw_exclusive: memread=%b memwrite=%b required not both", memread, memwrite);
      end
      if (memwrite && memready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_store: adr %h data %h with empty queue", adr, writedata);
        end else begin
          store_t e;
          e = exp_q.pop_front();
          chk("store_adr", adr, e.adr);
          chk("store_data", writedata, e.data);
        end
      end
    end
  end

  task automatic wait_ret(input int n);
    int g = 0;
    while (instret != n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (instret != n) chk("wait_instret_timeout", instret, n);
  endtask

  initial begin
    int cnt, g;
    reset = 1'b1;
    dinit = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memread", {31'd0, memread}, 32'd0);
    chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    dinit = 1'b0;

    // First pass: run into the store, hold it waiting, then abort it with reset.
    dstall = 1000;
    reset  = 1'b0;
    #1 chk("fetch_adr", adr, 32'h0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("instret_after12", instret, 32'd3);
    chk("pc_after12", pc, 32'd12);
    chk("ext0_trap", {31'd0, trap2}, 32'd1);
    chk("ext0_instret", instret2, 32'd0);
    chk("ext0_memread", {31'd0, memread2}, 32'd0);
    chk("ext0_pc", pc2, 32'd4);
    g = 0;
    while (!memwrite && g < 50) begin @(negedge clk); g++; end
    for (int i = 0; i < 3; i++) begin
      chk("wait_memwrite", {31'd0, memwrite}, 32'd1);
      chk("wait_adr", adr, 32'd84);
      chk("wait_wdata", writedata, 32'd17);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_memwrite_in_reset", {31'd0, memwrite}, 32'd0);
    dstall = 2;
    exp_q.push_back('{32'd84,  32'd17});
    exp_q.push_back('{32'd128, 32'd17});
    exp_q.push_back('{32'd132, 32'h0000FFFF});
    exp_q.push_back('{32'd136, 32'h000000F0});
    exp_q.push_back('{32'd140, 32'd1});
    exp_q.push_back('{32'd144, 32'd0});
    exp_q.push_back('{32'd148, 32'hFFFFFFF9});
    exp_q.push_back('{32'd152, 32'd13});
    reset = 1'b0;
    #1;
    chk("abort_memwrite", {31'd0, memwrite}, 32'd0);
    chk("abort_memread", {31'd0, memread}, 32'd1);
    chk("abort_adr", adr, 32'h0);
    chk("abort_instret", instret, 32'd0);
    chk("abort_mem84", mem[21], 32'hFC000000);

    // Second pass: full program with two wait states per data request.
    wait_ret(3);
    cnt = 0; g = 0;
    while (instret != 4 && g < 100) begin
      if (memwrite) cnt++;
      @(negedge clk);
      g++;
    end
    chk("sw_memwrite_cycles", cnt, 32'd3);
    cnt = 0;
    while (instret != 5 && cnt < 100) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    chk("lw_cycles", cnt, 32'd7);
    wait_ret(7);
    chk("j_pc", pc, 32'h20);
    cnt = 0;
    while (instret != 8 && cnt < 100) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    chk("beq_cycles", cnt, 32'd3);
    chk("beq_taken_pc", pc, 32'h2C);
    wait_ret(9);
    chk("bne_not_taken_pc", pc, 32'h30);
    wait_ret(24);
    chk("final_pc", pc, 32'h74);
    repeat (10) @(negedge clk);
    chk("trap_set", {31'd0, trap}, 32'd1);
    chk("trap_instret", instret, 32'd24);
    chk("trap_memread", {31'd0, memread}, 32'd0);
    chk("trap_pc", pc, 32'h78);
    chk("store_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
